// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin arbiter in front of one shared, external ALU.
// One operation in flight: grant in IDLE, capture in ISSUE, hold result in HOLD.
module alu_share_arbiter #(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   input  logic             req1_valid,
   output logic             req0_ready,
   output logic             req1_ready,
   input  logic [1:0]       req0_sel,
   input  logic [1:0]       req1_sel,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [1:0]       alu_sel,
   input  logic [WIDTH-1:0] alu_out,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   output logic             busy,
   output logic [7:0]       op_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic             ptr;
   logic             gnt_valid;
   logic             gnt;
   logic             gnt_id;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [1:0]       op_sel;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Grant selection, ready strobes and next-state decode.
   always_comb begin
      state_next = state;
      gnt_valid  = 1'b0;
      gnt        = 1'b0;
      if (!reset && state == IDLE) begin
         gnt_valid = req0_valid | req1_valid;
         // On a tie the requester not served last wins; otherwise the sole one.
         if (req0_valid && req1_valid) gnt = ~ptr;
         else                          gnt = req1_valid;
      end
      unique case (state)
         IDLE:    if (gnt_valid) state_next = ISSUE;
         ISSUE:   state_next = HOLD;
         HOLD:    if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
      req0_ready = gnt_valid & ~gnt;
      req1_ready = gnt_valid & gnt;
   end

   // Operand latch, result capture, handshake and completion counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr       <= 1'b1;
         gnt_id    <= 1'b0;
         op_a      <= '0;
         op_b      <= '0;
         op_sel    <= 2'd0;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_data  <= '0;
         op_count  <= 8'd0;
      end else begin
         if (state == IDLE && gnt_valid) begin
            ptr    <= gnt;
            gnt_id <= gnt;
            op_a   <= gnt ? req1_a : req0_a;
            op_b   <= gnt ? req1_b : req0_b;
            op_sel <= gnt ? req1_sel : req0_sel;
         end
         if (state == ISSUE) begin
            rsp_data  <= alu_out;
            rsp_id    <= gnt_id;
            rsp_valid <= 1'b1;
         end
         if (state == HOLD && rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + 8'd1;
         end
      end
   end

   assign alu_a   = op_a;
   assign alu_b   = op_b;
   assign alu_sel = op_sel;
   assign busy    = (state != IDLE);

endmodule
